// File: rtl/gac_if.sv
`default_nettype none
// ============================================================================
//  Interface : gac_if
//  Purpose   : Bundles the gac datapath (MD/PHV in from gme, out to scm),
//              the run status pulses and the 134-bit configuration chain.
//  Modports  : slave  - used by gac (consumes in_*/cin_*, drives out_*/cout_*)
//              master - used by the surrounding environment
//  Revision  : 1.0 - initial release
// ============================================================================
interface gac_if;
   // stream from gme
   logic [255:0]  in_gac_md;
   logic          in_gac_md_wr;
   logic          out_gac_md_alf;
   logic [1023:0] in_gac_phv;
   logic          in_gac_phv_wr;
   logic          out_gac_phv_alf;
   // stream to scm
   logic [255:0]  out_gac_md;
   logic          out_gac_md_wr;
   logic          in_gac_md_alf;
   logic [1023:0] out_gac_phv;
   logic          out_gac_phv_wr;
   logic          in_gac_phv_alf;
   // run status
   logic          gac2scm_sent_start;
   logic          gac2scm_sent_end;
   // configuration chain
   logic [133:0]  cin_gac_data;
   logic          cin_gac_data_wr;
   logic          cout_gac_ready;
   logic [133:0]  cout_gac_data;
   logic          cout_gac_data_wr;
   logic          cin_gac_ready;

   modport slave (
      input  in_gac_md, in_gac_md_wr, in_gac_phv, in_gac_phv_wr,
      input  in_gac_md_alf, in_gac_phv_alf,
      input  cin_gac_data, cin_gac_data_wr, cin_gac_ready,
      output out_gac_md_alf, out_gac_phv_alf,
      output out_gac_md, out_gac_md_wr, out_gac_phv, out_gac_phv_wr,
      output gac2scm_sent_start, gac2scm_sent_end,
      output cout_gac_ready, cout_gac_data, cout_gac_data_wr
   );

   modport master (
      output in_gac_md, in_gac_md_wr, in_gac_phv, in_gac_phv_wr,
      output in_gac_md_alf, in_gac_phv_alf,
      output cin_gac_data, cin_gac_data_wr, cin_gac_ready,
      input  out_gac_md_alf, out_gac_phv_alf,
      input  out_gac_md, out_gac_md_wr, out_gac_phv, out_gac_phv_wr,
      input  gac2scm_sent_start, gac2scm_sent_end,
      input  cout_gac_ready, cout_gac_data, cout_gac_data_wr
   );
endinterface
`default_nettype wire

// File: rtl/gac.sv
`default_nettype none
// ============================================================================
//  Module   : gac
//  Purpose  : Generator/arbiter in front of scm. Forwards the gme MD/PHV
//             stream with one register stage and, on command, injects a
//             programmed number of test packets into idle slots separated
//             by a programmed gap. Also a node on the configuration chain.
//  Ports    : clk, rst   - clock, synchronous active-high reset
//             bus        - gac_if.slave: MD/PHV in/out, almost-full pass-back,
//                          sent_start/sent_end pulses, config chain in/out
//  Revision : 1.0 - initial release
// ============================================================================
module gac #(
   parameter logic [7:0] LMID = 8'd6,
   parameter logic [7:0] NMID = 8'd7
) (
   input  logic clk,
   input  logic rst,
   gac_if.slave bus
);

   localparam logic [31:0] c_addr_ctrl   = 32'h6000_0001;
   localparam logic [31:0] c_addr_count  = 32'h6000_0002;
   localparam logic [31:0] c_addr_gap    = 32'h6000_0003;
   localparam logic [31:0] c_addr_proto  = 32'h6000_0004;
   localparam logic [31:0] c_addr_len    = 32'h6000_0005;
   localparam logic [31:0] c_addr_sent   = 32'h6000_0008;
   localparam logic [31:0] c_addr_status = 32'h6000_0009;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      INJECT = 2'd1,
      GAP    = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t         r_state;
   logic [31:0]    r_pkt_count;
   logic [15:0]    r_gap;
   logic [7:0]     r_proto;
   logic [11:0]    r_pkt_len;
   logic [31:0]    r_sent_cnt;
   logic [31:0]    r_seq;
   logic [15:0]    r_gap_cnt;
   logic           r_drop_tail;

   logic [255:0]   r_md;
   logic           r_md_wr;
   logic [1023:0]  r_phv;
   logic           r_phv_wr;
   logic           r_sent_start;
   logic           r_sent_end;
   logic [133:0]   r_cout_data;
   logic           r_cout_wr;

   // ---------------- configuration decode ----------------
   logic [133:0] w_cin;
   logic [31:0]  w_addr;
   logic [31:0]  w_data;
   logic         w_hdr, w_tail, w_mine, w_cfg_wr, w_cfg_rd;
   logic         w_start, w_abort;
   logic [31:0]  w_rd_val;

   assign w_cin    = bus.cin_gac_data;
   assign w_addr   = w_cin[95:64];
   assign w_data   = w_cin[31:0];
   assign w_hdr    = bus.cin_gac_data_wr && (w_cin[133:132] == 2'b01);
   assign w_tail   = bus.cin_gac_data_wr && (w_cin[133:132] == 2'b10);
   assign w_mine   = w_hdr && (w_cin[103:96] == LMID);
   assign w_cfg_wr = w_mine && (w_cin[126:124] == 3'b010);
   assign w_cfg_rd = w_mine && (w_cin[126:124] == 3'b001);
   // start and abort are command pulses; nothing of the ctrl word is stored
   assign w_start  = w_cfg_wr && (w_addr == c_addr_ctrl) && w_data[0];
   assign w_abort  = w_cfg_wr && (w_addr == c_addr_ctrl) && w_data[1];

   always_comb begin
      w_rd_val = 32'hFFFF_FFFF;
      case (w_addr)
         c_addr_count:  w_rd_val = r_pkt_count;
         c_addr_gap:    w_rd_val = {16'd0, r_gap};
         c_addr_proto:  w_rd_val = {24'd0, r_proto};
         c_addr_len:    w_rd_val = {20'd0, r_pkt_len};
         c_addr_sent:   w_rd_val = r_sent_cnt;
         c_addr_status: w_rd_val = {31'd0, (r_state != IDLE)};
         default:       w_rd_val = 32'hFFFF_FFFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pkt_count <= 32'd0;
         r_gap       <= 16'd0;
         r_proto     <= 8'd0;
         r_pkt_len   <= 12'd0;
      end else if (w_cfg_wr) begin
         case (w_addr)
            c_addr_count: r_pkt_count <= w_data;
            c_addr_gap:   r_gap       <= w_data[15:0];
            c_addr_proto: r_proto     <= w_data[7:0];
            c_addr_len:   r_pkt_len   <= w_data[11:0];
            default:      ;
         endcase
      end
   end

   // Config chain output: writes to this node swallow header and tail,
   // reads are answered in place of the header, everything else is forwarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cout_data <= '0;
         r_cout_wr   <= 1'b0;
         r_drop_tail <= 1'b0;
      end else begin
         r_cout_wr <= 1'b0;
         if (bus.cin_gac_data_wr) begin
            if (w_cfg_wr) begin
               r_drop_tail <= 1'b1;
            end else if (w_tail && r_drop_tail) begin
               r_drop_tail <= 1'b0;
            end else if (w_cfg_rd) begin
               r_cout_data <= {w_cin[133:128], 4'b1011, w_cin[123:112],
                               w_cin[103:96], w_cin[111:104],
                               w_cin[95:32], w_rd_val};
               r_cout_wr   <= 1'b1;
            end else begin
               r_cout_data <= w_cin;
               r_cout_wr   <= 1'b1;
            end
         end
      end
   end

   // ---------------- injection datapath and run FSM ----------------
   logic [255:0] w_inj_md;
   logic         w_slot;
   logic         w_fire;

   always_comb begin
      w_inj_md          = '0;
      w_inj_md[107:96]  = r_pkt_len;
      w_inj_md[87:80]   = NMID;
      w_inj_md[79:72]   = r_proto;
      w_inj_md[31:0]    = r_seq;
   end

   // Passthrough owns the output whenever gme writes; injection only uses
   // cycles where gme is silent and scm has room. Abort wins over a slot.
   assign w_slot = !bus.in_gac_md_wr && !bus.in_gac_md_alf && !bus.in_gac_phv_alf;
   assign w_fire = (r_state == INJECT) && w_slot && !w_abort;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_sent_cnt   <= 32'd0;
         r_seq        <= 32'd0;
         r_gap_cnt    <= 16'd0;
         r_md         <= '0;
         r_md_wr      <= 1'b0;
         r_phv        <= '0;
         r_phv_wr     <= 1'b0;
         r_sent_start <= 1'b0;
         r_sent_end   <= 1'b0;
      end else begin
         r_md_wr      <= bus.in_gac_md_wr | w_fire;
         r_phv_wr     <= bus.in_gac_phv_wr | w_fire;
         r_sent_start <= w_fire && (r_seq == 32'd0);
         r_sent_end   <= (r_state == DONE);

         if (bus.in_gac_md_wr)
            r_md <= bus.in_gac_md;
         else if (w_fire)
            r_md <= w_inj_md;

         if (bus.in_gac_phv_wr)
            r_phv <= bus.in_gac_phv;
         else if (w_fire)
            r_phv <= {992'd0, r_seq};

         case (r_state)
            IDLE: begin
               if (w_start && (r_pkt_count != 32'd0)) begin
                  r_state    <= INJECT;
                  r_sent_cnt <= 32'd0;
                  r_seq      <= 32'd0;
               end
            end
            INJECT: begin
               if (w_abort) begin
                  r_state <= DONE;
               end else if (w_fire) begin
                  r_sent_cnt <= r_sent_cnt + 32'd1;
                  r_seq      <= r_seq + 32'd1;
                  if (r_sent_cnt + 32'd1 == r_pkt_count) begin
                     r_state <= DONE;
                  end else if (r_gap != 16'd0) begin
                     r_gap_cnt <= r_gap;
                     r_state   <= GAP;
                  end
               end
            end
            GAP: begin
               if (w_abort) begin
                  r_state <= DONE;
               end else begin
                  r_gap_cnt <= r_gap_cnt - 16'd1;
                  if (r_gap_cnt == 16'd1)
                     r_state <= INJECT;
               end
            end
            DONE: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.out_gac_md_alf     = bus.in_gac_md_alf;
   assign bus.out_gac_phv_alf    = bus.in_gac_phv_alf;
   assign bus.out_gac_md         = r_md;
   assign bus.out_gac_md_wr      = r_md_wr;
   assign bus.out_gac_phv        = r_phv;
   assign bus.out_gac_phv_wr     = r_phv_wr;
   assign bus.gac2scm_sent_start = r_sent_start;
   assign bus.gac2scm_sent_end   = r_sent_end;
   assign bus.cout_gac_ready     = bus.cin_gac_ready;
   assign bus.cout_gac_data      = r_cout_data;
   assign bus.cout_gac_data_wr   = r_cout_wr;

endmodule
`default_nettype wire
